// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU package: fetch FSM state encoding, reset-vector default
// and a small PC arithmetic helper used by the fetch unit.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,   // no request outstanding
        ST_BUSY  = 2'b01,   // request for the current PC outstanding
        ST_FLUSH = 2'b10    // stale request outstanding, response is dropped
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Next sequential word address; wraps 0xFFFFFFFF -> 0x00000000.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_fetch_out_slot.sv
// Single-entry output slot between fetch and decode.
// A flush (redirect) beats a load, a load beats a drain, otherwise hold.
module fetch_out_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic        drain,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    // Slot register update: flush / load / drain / hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= 32'h0000_0000;
            pc    <= 32'h0000_0000;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (drain) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: keeps the PC, issues one instruction-memory
// read at a time, and presents fetched words to decode through a
// one-entry output slot. Redirects override everything; a request that
// is already on the bus is never withdrawn, its response is discarded.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    fetch_state_e state_r;
    logic [31:0]  pc_q;
    logic [31:0]  pc_inc_s;
    logic         slot_free_s;
    logic         slot_load_s;

    assign pc_inc_s = pc_next(pc_q);

    // Slot can take a new word if it is empty or being consumed this cycle.
    always_comb begin
        slot_free_s = 1'b0;
        if (!if_valid || if_ready) begin
            slot_free_s = 1'b1;
        end else begin
            slot_free_s = 1'b0;
        end
    end

    // Accept a response only for a live request, no redirect, and room in
    // the slot. A response that would overwrite an unconsumed word is
    // dropped and the same PC is fetched again once the slot drains.
    always_comb begin
        slot_load_s = 1'b0;
        if ((state_r == ST_BUSY) && imem_ack && !redirect_valid && slot_free_s) begin
            slot_load_s = 1'b1;
        end else begin
            slot_load_s = 1'b0;
        end
    end

    // Fetch FSM with registered request outputs and PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pc_q      <= RESET_VECTOR;
            imem_req  <= 1'b0;
            imem_addr <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_addr;
                    end else if (slot_free_s) begin
                        state_r   <= ST_BUSY;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_q;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_addr;
                        if (imem_ack) begin
                            state_r  <= ST_IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            state_r <= ST_FLUSH;
                        end
                    end else if (imem_ack) begin
                        if (!slot_free_s) begin
                            state_r  <= ST_IDLE;
                            imem_req <= 1'b0;
                        end else if (if_ready) begin
                            pc_q      <= pc_inc_s;
                            imem_addr <= pc_inc_s;
                        end else begin
                            pc_q     <= pc_inc_s;
                            state_r  <= ST_IDLE;
                            imem_req <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_FLUSH: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_addr;
                    end else begin
                        pc_q <= pc_q;
                    end
                    if (imem_ack) begin
                        state_r  <= ST_IDLE;
                        imem_req <= 1'b0;
                    end else begin
                        state_r <= ST_FLUSH;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    fetch_out_slot u_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (slot_load_s),
        .flush      (redirect_valid),
        .drain      (if_ready),
        .load_instr (imem_data),
        .load_pc    (imem_addr),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (RESET_VECTOR = 0x100).
// Memory model answers with addr ^ 0xA5A55A5A; ack is either automatic
// (same cycle as the request) or driven by hand for delayed responses.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        auto_ack;
    logic        man_ack;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign imem_ack  = imem_req & (auto_ack | man_ack);
    assign imem_data = imem_ack ? mem_word(imem_addr) : 32'h0000_0000;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_VECTOR(32'h0000_0100)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_data      (imem_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0000_0000;
        if_ready       = 1'b1;
        auto_ack       = 1'b0;
        man_ack        = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc",    if_pc, 32'h0);
        chk("rst_pcq",   dut.pc_q, 32'h0000_0100);

        // Sequential fetch with same-cycle ack
        reset    = 1'b0;
        auto_ack = 1'b1;
        tick();
        chk("first_req",  {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0000_0100);
        chk("first_vld",  {31'd0, if_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("seq_valid", {31'd0, if_valid}, 32'd1);
            chk("seq_pc",    if_pc, 32'h0000_0100 + i);
            chk("seq_instr", if_instr, mem_word(32'h0000_0100 + i));
        end

        // Decode stall: slot holds 0x102, pending response for 0x103 dropped
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_pc",    if_pc, 32'h0000_0102);
            chk("stall_instr", if_instr, mem_word(32'h0000_0102));
            chk("stall_req",   {31'd0, imem_req}, 32'd0);
            chk("stall_pcq",   dut.pc_q, 32'h0000_0103);
        end
        if_ready = 1'b1;
        tick();
        chk("resume_addr",  imem_addr, 32'h0000_0103);
        chk("resume_req",   {31'd0, imem_req}, 32'd1);
        chk("resume_drain", {31'd0, if_valid}, 32'd0);
        tick();
        chk("resume_pc",    if_pc, 32'h0000_0103);
        chk("resume_instr", if_instr, mem_word(32'h0000_0103));

        // Redirect while request outstanding: steer to 0x10 first
        auto_ack       = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0010;
        tick();
        chk("flush_addr", imem_addr, 32'h0000_0104);
        chk("flush_req",  {31'd0, imem_req}, 32'd1);
        chk("flush_vld",  {31'd0, if_valid}, 32'd0);
        redirect_valid = 1'b0;
        man_ack        = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("flush_done_req", {31'd0, imem_req}, 32'd0);
        chk("flush_done_vld", {31'd0, if_valid}, 32'd0);
        tick();
        chk("req10_addr", imem_addr, 32'h0000_0010);
        // Redirect to 0x2000 while 0x10 waits three cycles
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_2000;
        for (int i = 0; i < 3; i++) begin
            tick();
            redirect_valid = 1'b0;
            chk("wait10_addr", imem_addr, 32'h0000_0010);
            chk("wait10_req",  {31'd0, imem_req}, 32'd1);
            chk("wait10_vld",  {31'd0, if_valid}, 32'd0);
        end
        man_ack = 1'b1;
        tick();
        man_ack  = 1'b0;
        auto_ack = 1'b1;
        chk("drop10_vld", {31'd0, if_valid}, 32'd0);
        chk("drop10_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("req2000_addr", imem_addr, 32'h0000_2000);
        tick();
        chk("if2000_pc",    if_pc, 32'h0000_2000);
        chk("if2000_instr", if_instr, mem_word(32'h0000_2000));

        // Redirect coinciding with ack for 0x08
        auto_ack       = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0008;
        tick();
        redirect_valid = 1'b0;
        man_ack        = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        chk("req08_addr", imem_addr, 32'h0000_0008);
        man_ack        = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0040;
        tick();
        man_ack        = 1'b0;
        redirect_valid = 1'b0;
        auto_ack       = 1'b1;
        chk("drop08_vld", {31'd0, if_valid}, 32'd0);
        chk("drop08_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("req40_addr", imem_addr, 32'h0000_0040);
        tick();
        chk("if40_valid", {31'd0, if_valid}, 32'd1);
        chk("if40_pc",    if_pc, 32'h0000_0040);
        chk("if40_instr", if_instr, mem_word(32'h0000_0040));

        // PC wrap at 0xFFFFFFFF
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFF);
        tick();
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);
        chk("wrap_if_pc",     if_pc, 32'hFFFF_FFFF);
        tick();
        chk("wrap_if_pc0",    if_pc, 32'h0000_0000);
        chk("wrap_instr0",    if_instr, mem_word(32'h0000_0000));

        // Halt: redirect held to the same target
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0500;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_vld", {31'd0, if_valid}, 32'd0);
            chk("halt_req", {31'd0, imem_req}, 32'd0);
        end
        redirect_valid = 1'b0;
        tick();
        chk("unhalt_addr", imem_addr, 32'h0000_0500);

        // Reset mid-request
        auto_ack = 1'b0;
        reset    = 1'b1;
        tick();
        chk("midrst_req",   {31'd0, imem_req}, 32'd0);
        chk("midrst_vld",   {31'd0, if_valid}, 32'd0);
        chk("midrst_pcq",   dut.pc_q, 32'h0000_0100);
        chk("midrst_pc",    if_pc, 32'h0);
        chk("midrst_instr", if_instr, 32'h0);
        reset    = 1'b0;
        auto_ack = 1'b1;
        tick();
        chk("post_rst_req",  {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0000_0100);
        tick();
        chk("post_rst_pc",   if_pc, 32'h0000_0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
